res_tx_stage: RTL and testbench

// - Result transmit stage directly downstream of the ALU stage.
// - Consumes one {carry, res[17:0]} result via valid/ready and serialises it onto an 8-bit byte stream.
// - The byte stream goes to the chip output pins/host, again via valid/ready.
// - Adds a 2-bit sequence tag per result so the host can detect dropped or duplicated results.

---
 rtl/res_tx_stage_if.sv | 32 +++
 rtl/res_tx_stage.sv | 110 +++++++++++
 tb/tb_res_tx_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/res_tx_stage_if.sv
// ============================================================================
// Module : res_tx_stage_if
// Brief  : Result-in / byte-out handshake bundle for res_tx_stage.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface res_tx_stage_if;
    logic        res_valid;
    logic        res_ready;
    logic [17:0] res_q;
    logic        carry_q;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    // master: upstream ALU plus downstream sink; slave: the transmit stage
    modport master (
        output res_valid, res_q, carry_q, out_ready,
        input  res_ready, out_byte, out_valid, out_last, busy
    );

    modport slave (
        input  res_valid, res_q, carry_q, out_ready,
        output res_ready, out_byte, out_valid, out_last, busy
    );
endinterface

`default_nettype wire

// File: rtl/res_tx_stage.sv
// ============================================================================
// Module : res_tx_stage
// Brief  : Serialises a {carry, res[17:0]} result plus 2-bit sequence tag into
//          an 8-bit valid/ready byte stream. Macro RES_TX_CHKSUM_EN appends an
//          XOR checksum byte.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module res_tx_stage #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  wire          clk,
    input  wire          rst_n,
    res_tx_stage_if.slave bus
);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_SEND = 1'b1;

`ifdef RES_TX_CHKSUM_EN
    localparam logic [1:0] c_LAST_IDX = 2'd3;
`else
    localparam logic [1:0] c_LAST_IDX = 2'd2;
`endif

    logic [0:0]  r_state;
    logic [1:0]  r_idx;
    logic [1:0]  r_seq;
    logic [17:0] r_res;
    logic        r_carry;

    logic        w_send;
    logic        w_last;
    logic        w_fire_last;
    logic        w_res_ready;
    logic        w_take;
    logic [7:0]  w_b0;
    logic [7:0]  w_b1;
    logic [7:0]  w_b2;
    logic [7:0]  w_sel;

    assign w_send      = (r_state == c_S_SEND);
    assign w_last      = w_send && (r_idx == c_LAST_IDX);
    assign w_fire_last = w_last && bus.out_ready;
    // Accepting on the final-byte handshake lets frames run without a bubble
    assign w_res_ready = !w_send || w_fire_last;
    assign w_take      = bus.res_valid && w_res_ready;

    assign w_b0 = r_res[7:0];
    assign w_b1 = r_res[15:8];
    assign w_b2 = {r_seq, 3'b000, r_carry, r_res[17:16]};

`ifdef RES_TX_CHKSUM_EN
    logic [7:0] w_ck;
    assign w_ck = w_b0 ^ w_b1 ^ w_b2;
`endif

    always_comb begin
        w_sel = 8'h00;
        case (r_idx)
            2'd0:    w_sel = MSB_FIRST ? w_b2 : w_b0;
            2'd1:    w_sel = w_b1;
            2'd2:    w_sel = MSB_FIRST ? w_b0 : w_b2;
            default: begin
`ifdef RES_TX_CHKSUM_EN
                w_sel = w_ck;
`else
                w_sel = 8'h00;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_idx   <= 2'd0;
            r_seq   <= 2'd0;
            r_res   <= 18'd0;
            r_carry <= 1'b0;
        end else begin
            if (w_take) begin
                r_res   <= bus.res_q;
                r_carry <= bus.carry_q;
                r_idx   <= 2'd0;
                r_state <= c_S_SEND;
            end else if (w_fire_last) begin
                r_idx   <= 2'd0;
                r_state <= c_S_IDLE;
            end else if (w_send && bus.out_ready) begin
                r_idx   <= r_idx + 2'd1;
            end

            if (w_fire_last) begin
                r_seq <= r_seq + 2'd1;
            end
        end
    end

    assign bus.res_ready = w_res_ready;
    assign bus.out_valid = w_send;
    assign bus.out_last  = w_last;
    assign bus.out_byte  = w_send ? w_sel : 8'h00;
    assign bus.busy      = w_send;

endmodule

`default_nettype wire

// File: tb/tb_res_tx_stage.sv
// ============================================================================
// Module : tb_res_tx_stage
// Brief  : Directed self-checking bench for res_tx_stage (both byte orders).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_res_tx_stage;

`ifdef RES_TX_CHKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   exp_seq0;

    res_tx_stage_if bus0 ();
    res_tx_stage_if bus1 ();

    res_tx_stage #(.MSB_FIRST(1'b0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    res_tx_stage #(.MSB_FIRST(1'b1)) u_dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed frames for res=2A53C carry=1 seq=0 and res=1C3F1 carry=0 seq=1
    logic [7:0] c_basic_lsb [4] = '{8'h3C, 8'hA5, 8'h06, 8'h9F};
    logic [7:0] c_basic_msb [4] = '{8'h06, 8'hA5, 8'h3C, 8'h9F};
    logic [7:0] c_stall_lsb [4] = '{8'hF1, 8'hC3, 8'h41, 8'h73};

    logic [17:0] tab_r [5] = '{18'h00001, 18'h10203, 18'h2ABCD, 18'h3FFFF, 18'h00000};
    logic        tab_c [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    function automatic logic [7:0] exp_byte(input logic [17:0] r, input logic c,
                                            input logic [1:0] s, input int k);
        logic [7:0] b0, b1, b2;
        b0 = r[7:0];
        b1 = r[15:8];
        b2 = {s, 3'b000, c, r[17:16]};
        case (k)
            0:       return b0;
            1:       return b1;
            2:       return b2;
            default: return b0 ^ b1 ^ b2;
        endcase
    endfunction

    task automatic start0(input logic [17:0] r, input logic c);
        @(negedge clk);
        bus0.res_valid = 1'b1;
        bus0.res_q     = r;
        bus0.carry_q   = c;
        @(negedge clk);
        bus0.res_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_seq0 = 0;
        #1;
        n_tests++;
        if (bus0.out_valid !== 1'b0 || bus0.out_last !== 1'b0 || bus0.busy !== 1'b0 ||
            bus0.out_byte !== 8'h00 || bus0.res_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_lsb: got v=%b l=%b busy=%b byte=%h rdy=%b, want 0 0 0 00 1",
                     bus0.out_valid, bus0.out_last, bus0.busy, bus0.out_byte, bus0.res_ready);
        end
        n_tests++;
        if (bus1.out_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.res_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_msb: got v=%b busy=%b rdy=%b, want 0 0 1",
                     bus1.out_valid, bus1.busy, bus1.res_ready);
        end
    endtask

    task automatic test_basic;
        bus0.out_ready = 1'b1;
        start0(18'h2A53C, 1'b1);
        for (int k = 0; k < NB; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_tests++;
            if (bus0.out_valid !== 1'b1 || bus0.out_byte !== c_basic_lsb[k] ||
                bus0.out_last !== (k == NB-1) || bus0.res_ready !== (k == NB-1) ||
                bus0.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got v=%b byte=%h last=%b rdy=%b, want 1 %h %b %b",
                         k, bus0.out_valid, bus0.out_byte, bus0.out_last, bus0.res_ready,
                         c_basic_lsb[k], (k == NB-1), (k == NB-1));
            end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: got v=%b busy=%b, want 0 0", bus0.out_valid, bus0.busy);
        end
        exp_seq0++;
    endtask

    task automatic test_msb_first;
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.res_valid = 1'b1;
        bus1.res_q     = 18'h2A53C;
        bus1.carry_q   = 1'b1;
        @(negedge clk);
        bus1.res_valid = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_tests++;
            if (bus1.out_valid !== 1'b1 || bus1.out_byte !== c_basic_msb[k] ||
                bus1.out_last !== (k == NB-1)) begin
                n_fail++;
                $display("FAIL msb_byte%0d: got v=%b byte=%h last=%b, want 1 %h %b",
                         k, bus1.out_valid, bus1.out_byte, bus1.out_last,
                         c_basic_msb[k], (k == NB-1));
            end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus1.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL msb_end: got v=%b, want 0", bus1.out_valid);
        end
    endtask

    task automatic test_stall;
        int k;
        int c;
        k = 0;
        c = 0;
        start0(18'h1C3F1, 1'b0);
        while (k < NB && c < 30) begin
            bus0.out_ready = (c % 3 == 0);
            #1;
            n_tests++;
            if (bus0.out_valid !== 1'b1 || bus0.out_byte !== c_stall_lsb[k] ||
                bus0.out_last !== (k == NB-1)) begin
                n_fail++;
                $display("FAIL stall_c%0d: got v=%b byte=%h last=%b, want 1 %h %b",
                         c, bus0.out_valid, bus0.out_byte, bus0.out_last,
                         c_stall_lsb[k], (k == NB-1));
            end
            if (bus0.out_ready) k++;
            c++;
            @(negedge clk);
        end
        n_tests++;
        if (k != NB || c != 3*(NB-1)+1) begin
            n_fail++;
            $display("FAIL stall_count: got bytes=%0d cycles=%0d, want %0d %0d",
                     k, c, NB, 3*(NB-1)+1);
        end
        bus0.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus0.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: got v=%b, want 0", bus0.out_valid);
        end
        exp_seq0++;
    endtask

    task automatic test_back_to_back;
        int n;
        int got;
        int gaps;
        int cyc;
        int f;
        int k;
        logic [7:0] e;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_seq0 = 0;
        bus0.out_ready = 1'b1;
        n = 0; got = 0; gaps = 0; cyc = 0;
        while (got < 5*NB && cyc < 60) begin
            bus0.res_valid = (n < 5);
            bus0.res_q     = tab_r[(n < 5) ? n : 0];
            bus0.carry_q   = tab_c[(n < 5) ? n : 0];
            #1;
            if (bus0.out_valid === 1'b1) begin
                f = got / NB;
                k = got % NB;
                e = exp_byte(tab_r[f], tab_c[f], 2'(f), k);
                n_tests++;
                if (bus0.out_byte !== e || bus0.out_last !== (k == NB-1)) begin
                    n_fail++;
                    $display("FAIL b2b_f%0d_b%0d: got byte=%h last=%b, want %h %b",
                             f, k, bus0.out_byte, bus0.out_last, e, (k == NB-1));
                end
                if (k == 2) begin
                    n_tests++;
                    if (bus0.out_byte[7:6] !== 2'(f)) begin
                        n_fail++;
                        $display("FAIL b2b_tag%0d: got %0d, want %0d", f, bus0.out_byte[7:6], f % 4);
                    end
                end
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            if (bus0.res_valid && bus0.res_ready) n++;
            cyc++;
            @(negedge clk);
        end
        n_tests++;
        if (got != 5*NB || gaps != 0 || cyc != 1 + 5*NB) begin
            n_fail++;
            $display("FAIL b2b_stream: got bytes=%0d gaps=%0d cycles=%0d, want %0d 0 %0d",
                     got, gaps, cyc, 5*NB, 1 + 5*NB);
        end
        bus0.res_valid = 1'b0;
        #1;
        n_tests++;
        if (bus0.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got v=%b, want 0", bus0.out_valid);
        end
        exp_seq0 = 1;
    endtask

    task automatic test_hold_off;
        logic [7:0] e;
        bus0.out_ready = 1'b1;
        start0(18'h0BEEF, 1'b0);
        bus0.res_valid = 1'b1;
        bus0.res_q     = 18'h35A5A;
        bus0.carry_q   = 1'b1;
        for (int k = 0; k < NB; k++) begin
            #1;
            e = exp_byte(18'h0BEEF, 1'b0, 2'(exp_seq0), k);
            n_tests++;
            if (bus0.out_byte !== e || bus0.res_ready !== (k == NB-1)) begin
                n_fail++;
                $display("FAIL hold_a%0d: got byte=%h rdy=%b, want %h %b",
                         k, bus0.out_byte, bus0.res_ready, e, (k == NB-1));
            end
            @(negedge clk);
        end
        bus0.res_valid = 1'b0;
        exp_seq0++;
        for (int k = 0; k < NB; k++) begin
            #1;
            e = exp_byte(18'h35A5A, 1'b1, 2'(exp_seq0), k);
            n_tests++;
            if (bus0.out_valid !== 1'b1 || bus0.out_byte !== e) begin
                n_fail++;
                $display("FAIL hold_b%0d: got v=%b byte=%h, want 1 %h",
                         k, bus0.out_valid, bus0.out_byte, e);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (bus0.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_end: got v=%b, want 0", bus0.out_valid);
        end
        exp_seq0++;
    endtask

    task automatic test_reset_midframe;
        bus0.out_ready = 1'b1;
        start0(18'h2A53C, 1'b1);
        #1;
        n_tests++;
        if (bus0.out_byte !== 8'h3C) begin
            n_fail++;
            $display("FAIL midrst_first: got %h, want 3c", bus0.out_byte);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_seq0 = 0;
        #1;
        n_tests++;
        if (bus0.out_valid !== 1'b0 || bus0.res_ready !== 1'b1 || bus0.busy !== 1'b0 ||
            bus0.out_last !== 1'b0 || bus0.out_byte !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_state: got v=%b rdy=%b busy=%b last=%b byte=%h, want 0 1 0 0 00",
                     bus0.out_valid, bus0.res_ready, bus0.busy, bus0.out_last, bus0.out_byte);
        end
        start0(18'h2A53C, 1'b1);
        for (int k = 0; k < NB; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_tests++;
            if (bus0.out_valid !== 1'b1 || bus0.out_byte !== c_basic_lsb[k]) begin
                n_fail++;
                $display("FAIL midrst_byte%0d: got v=%b byte=%h, want 1 %h",
                         k, bus0.out_valid, bus0.out_byte, c_basic_lsb[k]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_seq0 = 0;
        rst_n = 1'b0;
        bus0.res_valid = 1'b0; bus0.res_q = 18'd0; bus0.carry_q = 1'b0; bus0.out_ready = 1'b0;
        bus1.res_valid = 1'b0; bus1.res_q = 18'd0; bus1.carry_q = 1'b0; bus1.out_ready = 1'b0;

        test_reset();
        test_basic();
        test_msb_first();
        test_stall();
        test_back_to_back();
        test_hold_off();
        test_reset_midframe();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
